// File: rtl/nonrestoring_divider.sv
// Sequential radix-2 non-restoring divider with start/done handshake.
// Signed mode works on magnitudes and re-applies the recorded signs at the end.
module nonrestoring_divider #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ITER    = 3'd2,
    S_CORRECT = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t                  state;
  logic [CW-1:0]           count;
  logic [WIDTH-1:0]        dvd_raw;
  logic [WIDTH-1:0]        dvs_raw;
  logic [WIDTH-1:0]        d_mag;
  logic [WIDTH-1:0]        q_acc;
  logic signed [WIDTH+1:0] r_acc;
  logic                    q_neg;
  logic                    r_neg;

  logic signed [WIDTH+1:0] d_ext;
  logic signed [WIDTH+1:0] r_shift;
  logic signed [WIDTH+1:0] r_next;
  logic signed [WIDTH+1:0] r_fix;

  // Magnitude as an unsigned WIDTH-bit value; the most-negative input maps to
  // 2^(WIDTH-1), which still fits because the result is treated as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    if (SIGNED != 0 && x[WIDTH-1])
      magnitude = -x;
    else
      magnitude = x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                  input logic             neg);
    if (neg)
      apply_sign = -x;
    else
      apply_sign = x;
  endfunction

  function automatic logic is_negative(input logic [WIDTH-1:0] x);
    is_negative = (SIGNED != 0) && x[WIDTH-1];
  endfunction

  // Zero-extended divisor: the datapath never sign-extends a magnitude.
  always_comb begin
    d_ext   = $signed({2'b00, d_mag});
    r_shift = $signed({r_acc[WIDTH:0], q_acc[WIDTH-1]});
    if (r_acc[WIDTH+1])
      r_next = r_shift + d_ext;
    else
      r_next = r_shift - d_ext;
    if (r_acc[WIDTH+1])
      r_fix = r_acc + d_ext;
    else
      r_fix = r_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= '0;
      dvd_raw   <= '0;
      dvs_raw   <= '0;
      d_mag     <= '0;
      q_acc     <= '0;
      r_acc     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd_raw  <= dividend;
            dvs_raw  <= divisor;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          d_mag <= magnitude(dvs_raw);
          q_acc <= magnitude(dvd_raw);
          r_acc <= '0;
          q_neg <= is_negative(dvd_raw) ^ is_negative(dvs_raw);
          r_neg <= is_negative(dvd_raw);
          count <= '0;
          if (dvs_raw == '0)
            state <= S_FINISH;
          else
            state <= S_ITER;
        end

        S_ITER: begin
          r_acc <= r_next;
          q_acc <= {q_acc[WIDTH-2:0], ~r_next[WIDTH+1]};
          count <= count + 1'b1;
          if (count == LAST_COUNT)
            state <= S_CORRECT;
        end

        S_CORRECT: begin
          r_acc <= r_fix;
          state <= S_FINISH;
        end

        S_FINISH: begin
          if (dvs_raw == '0) begin
            quotient  <= ALL_ONES;
            remainder <= dvd_raw;
            div_zero  <= 1'b1;
            overflow  <= 1'b0;
          end else begin
            // most-negative / -1 wraps back to most-negative by plain negation
            quotient  <= apply_sign(q_acc, q_neg);
            remainder <= apply_sign(r_acc[WIDTH-1:0], r_neg);
            div_zero  <= 1'b0;
            overflow  <= (SIGNED != 0) && (dvd_raw == MOST_NEG) && (dvs_raw == ALL_ONES);
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider: signed and unsigned instances
// share clock and reset; each scenario task checks its own results inline.
module tb_nonrestoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start_s = 1'b0;
  logic [7:0] dvd_s = '0, dvs_s = '0;
  logic [7:0] q_s, r_s;
  logic       busy_s, done_s, dz_s, ov_s;

  logic       start_u = 1'b0;
  logic [7:0] dvd_u = '0, dvs_u = '0;
  logic [7:0] q_u, r_u;
  logic       busy_u, done_u, dz_u, ov_u;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  nonrestoring_divider #(.WIDTH(8), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .dividend(dvd_s), .divisor(dvs_s),
    .quotient(q_s), .remainder(r_s), .busy(busy_s), .done(done_s),
    .div_zero(dz_s), .overflow(ov_s));

  nonrestoring_divider #(.WIDTH(8), .SIGNED(0)) u_u (
    .clk(clk), .rst_n(rst_n), .start(start_u), .dividend(dvd_u), .divisor(dvs_u),
    .quotient(q_u), .remainder(r_u), .busy(busy_u), .done(done_u),
    .div_zero(dz_u), .overflow(ov_u));

  // Called 1 time unit after a rising edge; returns cycles from accept edge to done.
  task automatic run_s(input logic [7:0] a, input logic [7:0] b, output int cyc);
    start_s = 1'b1; dvd_s = a; dvs_s = b;
    @(posedge clk); #1;
    start_s = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done_s) break;
    end
  endtask

  task automatic run_u(input logic [7:0] a, input logic [7:0] b, output int cyc);
    start_u = 1'b1; dvd_u = a; dvs_u = b;
    @(posedge clk); #1;
    start_u = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done_u) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({q_s, r_s, busy_s, done_s, dz_s, ov_s} !== 20'h0) begin
      nerr++; $display("FAIL reset_signed: got %h want 0", {q_s, r_s, busy_s, done_s, dz_s, ov_s});
    end
    nchk++;
    if ({q_u, r_u, busy_u, done_u, dz_u, ov_u} !== 20'h0) begin
      nerr++; $display("FAIL reset_unsigned: got %h want 0", {q_u, r_u, busy_u, done_u, dz_u, ov_u});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc;
    int busy_low;
    start_s = 1'b1; dvd_s = 8'h64; dvs_s = 8'h07;
    @(posedge clk); #1;
    start_s = 1'b0;
    cyc = 0; busy_low = 0;
    while (cyc < 40) begin
      if (!busy_s) busy_low++;
      @(posedge clk); #1;
      cyc++;
      if (done_s) break;
    end
    nchk++;
    if (cyc !== 11) begin nerr++; $display("FAIL basic_latency: got %0d want 11", cyc); end
    nchk++;
    if (busy_low !== 0) begin nerr++; $display("FAIL basic_busy: busy low %0d cycles, want 0", busy_low); end
    nchk++;
    if (q_s !== 8'h0E || r_s !== 8'h02) begin
      nerr++; $display("FAIL basic_100_7: got q=%h r=%h want q=0e r=02", q_s, r_s);
    end
    nchk++;
    if (busy_s !== 1'b0 || dz_s !== 1'b0 || ov_s !== 1'b0) begin
      nerr++; $display("FAIL basic_flags: got busy=%b dz=%b ov=%b want 0 0 0", busy_s, dz_s, ov_s);
    end
    @(posedge clk); #1;
    nchk++;
    if (done_s !== 1'b0) begin nerr++; $display("FAIL basic_done_pulse: got %b want 0", done_s); end
  endtask

  task automatic test_signs();
    logic [7:0] a [3] = '{8'h9C, 8'h64, 8'h9C};
    logic [7:0] b [3] = '{8'h07, 8'hF9, 8'hF9};
    logic [7:0] eq [3] = '{8'hF2, 8'hF2, 8'h0E};
    logic [7:0] er [3] = '{8'hFE, 8'h02, 8'hFE};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      run_s(a[i], b[i], cyc);
      nchk++;
      if (cyc !== 11 || q_s !== eq[i] || r_s !== er[i]) begin
        nerr++;
        $display("FAIL signs_%0d: got q=%h r=%h cyc=%0d want q=%h r=%h cyc=11",
                 i, q_s, r_s, cyc, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    run_s(8'h05, 8'h00, cyc);
    nchk++;
    if (cyc !== 2) begin nerr++; $display("FAIL dz_latency: got %0d want 2", cyc); end
    nchk++;
    if (q_s !== 8'hFF || r_s !== 8'h05 || dz_s !== 1'b1 || ov_s !== 1'b0) begin
      nerr++; $display("FAIL dz_result: got q=%h r=%h dz=%b ov=%b want ff 05 1 0", q_s, r_s, dz_s, ov_s);
    end
    // next valid start clears the flag on its accepting edge
    start_s = 1'b1; dvd_s = 8'h64; dvs_s = 8'h07;
    @(posedge clk); #1;
    start_s = 1'b0;
    nchk++;
    if (dz_s !== 1'b0) begin nerr++; $display("FAIL dz_clear: got %b want 0", dz_s); end
    nchk++;
    if (q_s !== 8'hFF) begin nerr++; $display("FAIL dz_hold_q: got %h want ff", q_s); end
    cyc = 0;
    while (cyc < 40 && !done_s) begin @(posedge clk); #1; cyc++; end
    nchk++;
    if (q_s !== 8'h0E || r_s !== 8'h02) begin
      nerr++; $display("FAIL dz_followup: got q=%h r=%h want 0e 02", q_s, r_s);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    run_s(8'h80, 8'hFF, cyc);
    nchk++;
    if (q_s !== 8'h80 || r_s !== 8'h00 || ov_s !== 1'b1 || dz_s !== 1'b0) begin
      nerr++; $display("FAIL ovf_m128_m1: got q=%h r=%h ov=%b dz=%b want 80 00 1 0", q_s, r_s, ov_s, dz_s);
    end
    run_s(8'h80, 8'h01, cyc);
    nchk++;
    if (q_s !== 8'h80 || r_s !== 8'h00 || ov_s !== 1'b0) begin
      nerr++; $display("FAIL ovf_m128_p1: got q=%h r=%h ov=%b want 80 00 0", q_s, r_s, ov_s);
    end
  endtask

  task automatic test_unsigned();
    logic [7:0] a [3] = '{8'd200, 8'd255, 8'd7};
    logic [7:0] b [3] = '{8'd3, 8'd255, 8'd9};
    logic [7:0] eq [3] = '{8'd66, 8'd1, 8'd0};
    logic [7:0] er [3] = '{8'd2, 8'd0, 8'd7};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      run_u(a[i], b[i], cyc);
      nchk++;
      if (cyc !== 11 || q_u !== eq[i] || r_u !== er[i] || ov_u !== 1'b0) begin
        nerr++;
        $display("FAIL unsigned_%0d: got q=%0d r=%0d cyc=%0d ov=%b want q=%0d r=%0d cyc=11 ov=0",
                 i, q_u, r_u, cyc, ov_u, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_start_during_iter();
    int cyc;
    start_s = 1'b1; dvd_s = 8'h64; dvs_s = 8'h07;
    @(posedge clk); #1;
    start_s = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      if (cyc == 4) begin start_s = 1'b1; dvd_s = 8'h32; dvs_s = 8'h05; end
      else start_s = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (done_s) break;
    end
    start_s = 1'b0;
    nchk++;
    if (cyc !== 11 || q_s !== 8'h0E || r_s !== 8'h02) begin
      nerr++; $display("FAIL start_ignored: got q=%h r=%h cyc=%0d want 0e 02 11", q_s, r_s, cyc);
    end
    @(posedge clk); #1;
    nchk++;
    if (busy_s !== 1'b0) begin nerr++; $display("FAIL start_ignored_idle: busy=%b want 0", busy_s); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    start_s = 1'b1; dvd_s = 8'h9C; dvs_s = 8'h07;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({q_s, r_s, busy_s, done_s, dz_s, ov_s} !== 20'h0) begin
      nerr++; $display("FAIL reset_mid: got %h want 0", {q_s, r_s, busy_s, done_s, dz_s, ov_s});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_s || busy_s) seen_done++;
    end
    nchk++;
    if (seen_done !== 0) begin nerr++; $display("FAIL reset_mid_no_done: %0d active cycles, want 0", seen_done); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_s(8'h64, 8'h07, cyc);
    nchk++;
    if (done_s !== 1'b1 || q_s !== 8'h0E) begin
      nerr++; $display("FAIL b2b_first: got done=%b q=%h want 1 0e", done_s, q_s);
    end
    run_s(8'h9C, 8'h07, cyc);
    nchk++;
    if (cyc !== 11 || q_s !== 8'hF2 || r_s !== 8'hFE) begin
      nerr++; $display("FAIL b2b_second: got q=%h r=%h cyc=%0d want f2 fe 11", q_s, r_s, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_unsigned();
    test_start_during_iter();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
